// File: rtl/div_ctrl_pkg.sv
// Shared definitions for the execute-stage divide sequencer: FSM state
// encoding and the R-type funct codes the decoder uses to raise startE/signedE.
package div_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DZERO = 2'd2,
    DONE  = 2'd3
  } divState_t;

  localparam logic [5:0] FUNCT_DIV  = 6'h1A;
  localparam logic [5:0] FUNCT_DIVU = 6'h1B;

  // Decoder helpers: which funct codes start the divider, and which are signed.
  function automatic logic isDivFunct(input logic [5:0] funct);
    return (funct == FUNCT_DIV) || (funct == FUNCT_DIVU);
  endfunction

  function automatic logic isSignedDiv(input logic [5:0] funct);
    return funct == FUNCT_DIV;
  endfunction

endpackage

// File: rtl/div_ctrl_core.sv
// Radix-2 restoring shift-subtract datapath working on unsigned magnitudes.
// One quotient bit is resolved per step; sign handling lives in div_ctrl.
module div_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] aMag,
  input  logic [WIDTH-1:0] bMag,
  output logic [WIDTH-1:0] quo,
  output logic [WIDTH-1:0] rem
);

  logic [WIDTH-1:0] remReg;
  logic [WIDTH-1:0] quoReg;
  logic [WIDTH-1:0] divReg;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic             geq;
  logic [WIDTH-1:0] remNext;

  // The shifted partial remainder needs one extra bit: with a divisor above
  // 2^(WIDTH-1) it can exceed WIDTH bits before the subtraction.
  always_comb begin
    shifted = {remReg, quoReg[WIDTH-1]};
    diff    = shifted - {1'b0, divReg};
    geq     = ~diff[WIDTH];
    remNext = geq ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      remReg <= '0;
      quoReg <= '0;
      divReg <= '0;
    end else if (load) begin
      remReg <= '0;
      quoReg <= aMag;
      divReg <= bMag;
    end else if (step) begin
      remReg <= remNext;
      quoReg <= {quoReg[WIDTH-2:0], geq};
    end
  end

  assign quo = quoReg;
  assign rem = remReg;

endmodule

// File: rtl/div_ctrl.sv
// Divide sequencer for the execute stage: FSM, iteration counter, sign fixup
// and the stall/ready handshake around div_core.
module div_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             startE,
  input  logic             signedE,
  input  logic             annulE,
  input  logic [WIDTH-1:0] aE,
  input  logic [WIDTH-1:0] bE,
  output logic             stallE,
  output logic             readyE,
  output logic [WIDTH-1:0] hiE,
  output logic [WIDTH-1:0] loE
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  divState_t        stateReg, stateNext;
  logic [CW-1:0]    cntReg;
  logic             qSignReg, rSignReg, dzReg;
  logic [WIDTH-1:0] aRawReg, hiReg, loReg;
  logic             accept, load, step;
  logic [WIDTH-1:0] aMag, bMag, quo, rem, loFix, hiFix;

  assign accept = (stateReg == IDLE) && startE && !annulE;
  assign aMag   = (signedE && aE[WIDTH-1]) ? -aE : aE;
  assign bMag   = (signedE && bE[WIDTH-1]) ? -bE : bE;

  always_comb begin
    stateNext = stateReg;
    load      = 1'b0;
    step      = 1'b0;
    case (stateReg)
      IDLE: begin
        if (accept) begin
          if (bE != '0) begin
            load      = 1'b1;
            stateNext = BUSY;
          end else begin
            stateNext = DZERO;
          end
        end
      end
      BUSY: begin
        step = 1'b1;
        if (cntReg == CW'(WIDTH - 1)) stateNext = DONE;
      end
      DZERO:   stateNext = DONE;
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
    // A flush wins over everything, including the ready cycle.
    if (annulE) begin
      stateNext = IDLE;
      load      = 1'b0;
      step      = 1'b0;
    end
  end

  div_core #(.WIDTH(WIDTH)) uCore (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .step (step),
    .aMag (aMag),
    .bMag (bMag),
    .quo  (quo),
    .rem  (rem)
  );

  always_comb begin
    loFix = dzReg ? '1 : (qSignReg ? -quo : quo);
    hiFix = dzReg ? aRawReg : (rSignReg ? -rem : rem);
  end

  assign readyE = (stateReg == DONE) && !annulE;
  assign stallE = startE && !readyE;
  // The result is visible in the ready cycle itself and held afterwards.
  assign hiE    = readyE ? hiFix : hiReg;
  assign loE    = readyE ? loFix : loReg;

  always_ff @(posedge clk) begin
    if (rst) begin
      stateReg <= IDLE;
      cntReg   <= '0;
      qSignReg <= 1'b0;
      rSignReg <= 1'b0;
      dzReg    <= 1'b0;
      aRawReg  <= '0;
      hiReg    <= '0;
      loReg    <= '0;
    end else begin
      stateReg <= stateNext;
      if (load) begin
        cntReg   <= '0;
        qSignReg <= (aE[WIDTH-1] ^ bE[WIDTH-1]) & signedE;
        rSignReg <= aE[WIDTH-1] & signedE;
        dzReg    <= 1'b0;
      end else if (accept) begin
        dzReg   <= 1'b1;
        aRawReg <= aE;
      end
      if (step) cntReg <= cntReg + CW'(1);
      if (readyE) begin
        hiReg <= hiFix;
        loReg <= loFix;
      end
    end
  end

endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl: a latency/arithmetic model checked every cycle,
// plus literal expectations on each directed operation.
module tb_div_ctrl;

  logic        clk = 1'b0;
  logic        rst, startE, signedE, annulE;
  logic [31:0] aE, bE;
  logic        stallE, readyE;
  logic [31:0] hiE, loE;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  bit cmpEn = 1'b0;

  always #5 clk = ~clk;

  div_ctrl #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .startE(startE), .signedE(signedE), .annulE(annulE),
    .aE(aE), .bE(bE), .stallE(stallE), .readyE(readyE), .hiE(hiE), .loE(loE)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endtask

  // Model: plain arithmetic for the result, cycle counting for the latency.
  logic        mActive = 1'b0;
  int          mCnt = 0, mLat = 0;
  logic [31:0] mLo, mHi, mHeldLo = '0, mHeldHi = '0;
  logic        mReady;

  function automatic void calc(input logic [31:0] a, input logic [31:0] b, input logic s,
                               output logic [31:0] lo, output logic [31:0] hi);
    if (b == 0) begin lo = '1; hi = a; end
    else if (!s) begin lo = a / b; hi = a % b; end
    else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin lo = 32'h8000_0000; hi = 0; end
    else begin lo = $signed(a) / $signed(b); hi = $signed(a) % $signed(b); end
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      mActive = 1'b0; mHeldLo = '0; mHeldHi = '0;
    end else if (mActive) begin
      if (annulE) mActive = 1'b0;
      else if (mCnt == mLat) begin
        mHeldLo = mLo; mHeldHi = mHi; mActive = 1'b0;
      end else mCnt++;
    end else if (startE && !annulE) begin
      mActive = 1'b1; mCnt = 1;
      mLat = (bE == 0) ? 2 : 33;
      calc(aE, bE, signedE, mLo, mHi);
    end
  end

  assign mReady = mActive && (mCnt == mLat) && !annulE;

  always @(negedge clk) begin
    if (cmpEn) begin
      chk("readyE", {31'b0, readyE}, {31'b0, mReady});
      chk("stallE", {31'b0, stallE}, {31'b0, startE & ~mReady});
      chk("loE", loE, mReady ? mLo : mHeldLo);
      chk("hiE", hiE, mReady ? mHi : mHeldHi);
    end
    if (cyc > 5000) begin
      $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
      $fatal(1);
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic startOp(input logic [31:0] a, input logic [31:0] b, input logic s,
                         output int t0);
    aE = a; bE = b; signedE = s; startE = 1'b1;
    t0 = cyc;
  endtask

  task automatic waitReady(input int t0, input int lat, input logic [31:0] eLo,
                           input logic [31:0] eHi, input string nm);
    bit got = 1'b0;
    for (int k = 0; k < 80 && !got; k++) begin
      tick();
      if (readyE) got = 1'b1;
    end
    if (!got) begin
      compared++; mismatched++;
      $display("FAIL %s_timeout got=no_ready want=ready_at_T+%0d", nm, lat);
    end else begin
      chk({nm, "_lat"}, cyc - t0, lat);
      chk({nm, "_lo"}, loE, eLo);
      chk({nm, "_hi"}, hiE, eHi);
      $display("op %s: lat=%0d lo=%h hi=%h", nm, cyc - t0, loE, hiE);
    end
  endtask

  task automatic doOp(input logic [31:0] a, input logic [31:0] b, input logic s,
                      input int lat, input logic [31:0] eLo, input logic [31:0] eHi,
                      input string nm);
    int t0;
    startOp(a, b, s, t0);
    waitReady(t0, lat, eLo, eHi, nm);
    tick(); startE = 1'b0;
    tick();
  endtask

  initial begin
    int t0, t1;
    rst = 1'b1; startE = 1'b0; signedE = 1'b0; annulE = 1'b0; aE = '0; bE = '0;
    tick(); tick();
    cmpEn = 1'b1;
    chk("rst_ready", {31'b0, readyE}, 32'd0);
    chk("rst_lo", loE, 32'd0);
    chk("rst_hi", hiE, 32'd0);
    rst = 1'b0;
    tick();

    doOp(32'd100, 32'd7, 1'b0, 33, 32'd14, 32'd2, "divu_100_7");
    chk("idle_stall", {31'b0, stallE}, 32'd0);
    doOp(32'hFFFF_FFF9, 32'd2, 1'b1, 33, 32'hFFFF_FFFD, 32'hFFFF_FFFF, "div_m7_2");
    doOp(32'hFFFF_FFF9, 32'd2, 1'b0, 33, 32'h7FFF_FFFC, 32'd1, "divu_big_2");
    doOp(32'hFFFF_FF9C, 32'd7, 1'b1, 33, 32'hFFFF_FFF2, 32'hFFFF_FFFE, "div_m100_7");
    doOp(32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 33, 32'd1, 32'h7FFF_FFFF, "divu_maxdiv");
    doOp(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 33, 32'h8000_0000, 32'd0, "div_min_m1");
    doOp(32'd5, 32'd0, 1'b1, 2, 32'hFFFF_FFFF, 32'd5, "div_5_0");

    // Flush mid-operation, then a fresh request two cycles later.
    startOp(32'd1000, 32'd10, 1'b0, t0);
    repeat (10) tick();
    annulE = 1'b1; startE = 1'b0;
    tick();
    annulE = 1'b0;
    tick();
    chk("annul_hold_lo", loE, 32'hFFFF_FFFF);
    chk("annul_hold_hi", hiE, 32'd5);
    startOp(32'd9, 32'd4, 1'b0, t1);
    chk("annul_restart_at", t1 - t0, 12);
    waitReady(t0, 45, 32'd2, 32'd1, "annul_then_9_4");
    tick(); startE = 1'b0;
    tick();

    // Reset mid-operation with startE held high across it.
    startOp(32'd100, 32'd7, 1'b0, t0);
    repeat (20) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_ready", {31'b0, readyE}, 32'd0);
    chk("midrst_lo", loE, 32'd0);
    chk("midrst_hi", hiE, 32'd0);
    waitReady(t0 + 21, 33, 32'd14, 32'd2, "after_rst_100_7");
    tick(); startE = 1'b0;
    tick();

    // Back-to-back requests with startE never dropping.
    startOp(32'd6, 32'd3, 1'b0, t0);
    waitReady(t0, 33, 32'd2, 32'd0, "b2b_6_3");
    tick();
    aE = 32'd7; bE = 32'd3;
    t1 = cyc;
    waitReady(t1, 33, 32'd2, 32'd1, "b2b_7_3");
    chk("b2b_total_lat", cyc - t0, 67);
    tick(); startE = 1'b0;
    tick(); tick();

    cmpEn = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
